// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider.
//   start       - request a divide (sampled only while the divider is idle)
//   signed_div  - 1 = DIV (two's-complement), 0 = DIVU
//   annul       - flush/exception kill of the in-flight divide
//   a, b        - dividend (rs) and divisor (rt)
//   stall       - hold the pipeline while the divide is accepted or running
//   result_valid- one-cycle pulse; lo/hi carry the new result
//   lo, hi      - quotient and remainder for the hilo write path
// master: execute stage side. slave: divider side.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic             signed_div;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start,
    output signed_div,
    output annul,
    output a,
    output b,
    input  stall,
    input  result_valid,
    input  lo,
    input  hi
  );

  modport slave (
    input  start,
    input  signed_div,
    input  annul,
    input  a,
    input  b,
    output stall,
    output result_valid,
    output lo,
    output hi
  );

endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Works on operand magnitudes for WIDTH cycles, then applies the quotient/remainder
// sign fixups and presents quotient on lo and remainder on hi with a result_valid pulse.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   div_if - slave side of div_unit_if (start/signed_div/annul/a/b in,
//            stall/result_valid/lo/hi out)
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  div_unit_if.slave  div_if
);

  // Wide enough to hold WIDTH itself.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;  // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic             accept;
  logic             commit;
  logic             last_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  assign accept    = (state_q == StIdle) & div_if.start & ~div_if.annul;
  assign commit    = (state_q == StDone) & ~div_if.annul;
  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  // Magnitudes are plain WIDTH-bit unsigned values, so |0x80000000| wraps to
  // 0x80000000 and the overflow case falls out of the normal fixups.
  assign a_mag = (div_if.signed_div & div_if.a[WIDTH-1]) ? -div_if.a : div_if.a;
  assign b_mag = (div_if.signed_div & div_if.b[WIDTH-1]) ? -div_if.b : div_if.b;

  // Restoring step. The partial remainder is always below the divisor, so a
  // WIDTH+1-bit difference is enough and its MSB is the borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  assign res_lo = q_neg_q ? -quo_q : quo_q;
  assign res_hi = r_neg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvsr_d  = b_mag;
          q_neg_d = div_if.signed_div & (div_if.a[WIDTH-1] ^ div_if.b[WIDTH-1]);
          r_neg_d = div_if.signed_div & div_if.a[WIDTH-1];
        end
      end

      StRun: begin
        if (div_if.annul) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (trial[WIDTH]) begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end
          if (last_step) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // lo/hi outputs show the fixed-up result during DONE so the instruction
  // released from EX commits it alongside result_valid; an annul in DONE
  // falls back to the held value and skips the update.
  assign lo_d = commit ? res_lo : lo_q;
  assign hi_d = commit ? res_hi : hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign div_if.stall        = accept | (state_q == StRun);
  assign div_if.result_valid = commit;
  assign div_if.lo           = lo_d;
  assign div_if.hi           = hi_d;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb_q[$];
  logic [63:0] exp_v;
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  typedef struct {
    bit          sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  // Reference: quotient/remainder with truncation toward zero and the
  // divide-by-zero / overflow results the divider defines.
  function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) begin
      q = (sd && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
      r = a;
    end else if (!sd) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start for the current cycle; optionally record the expected result.
  task automatic drive(input bit sd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi, input bit push);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.a          = a;
    bus.b          = b;
    if (push) sb_q.push_back({elo, ehi});
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul      = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    step();
    step();
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", bus.stall);
    end
    checks++;
    if (bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.result_valid);
    end
    checks++;
    if (bus.lo !== 32'h0 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL reset_lohi got %h/%h want 0/0", bus.lo, bus.hi);
    end
    @(negedge clk);
    rst = 1'b0;
    last_lo = '0;
    last_hi = '0;
    step();
  endtask

  task automatic test_divu_timing();
    bit bad;
    drive(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL divu_stall_n got %b want 1", bus.stall);
    end
    step();
    bus.start = 1'b0;
    bad = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1 || bus.result_valid !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL divu_run cycle N+%0d stall %b valid %b want 1/0", i, bus.stall,
                 bus.result_valid);
      end
      step();
    end
    checks++;
    if (bad) errors++;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL divu_done stall %b valid %b want 0/1", bus.stall, bus.result_valid);
    end else begin
      exp_v = sb_q.pop_front();
      checks++;
      if ({bus.lo, bus.hi} !== exp_v) begin
        errors++; $display("FAIL divu_result got %h/%h want %h/%h", bus.lo, bus.hi,
                           exp_v[63:32], exp_v[31:0]);
      end
      last_lo = exp_v[63:32];
      last_hi = exp_v[31:0];
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.lo !== last_lo || bus.hi !== last_hi) begin
      errors++; $display("FAIL divu_hold valid %b lo/hi %h/%h want 0 %h/%h", bus.result_valid,
                         bus.lo, bus.hi, last_lo, last_hi);
    end
    step();
  endtask

  // Signed, overflow and divide-by-zero cases issued back to back.
  task automatic test_back_to_back();
    vec_t tbl[5];
    tbl[0] = '{1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    tbl[1] = '{1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1};
    tbl[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    tbl[3] = '{1'b0, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5};
    tbl[4] = '{1'b1, 32'hFFFF_FFFB, 32'h0, 32'h1, 32'hFFFF_FFFB};
    for (int k = 0; k < 5; k++) begin
      drive(tbl[k].sd, tbl[k].a, tbl[k].b, tbl[k].lo, tbl[k].hi, 1'b1);
      step();
      bus.start = 1'b0;
      repeat (W - 1) step();
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b0 || bus.stall !== 1'b1) begin
        errors++; $display("FAIL b2b_early[%0d] valid %b stall %b want 0/1", k,
                           bus.result_valid, bus.stall);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_valid[%0d] got %b want 1", k, bus.result_valid);
      end else begin
        exp_v = sb_q.pop_front();
        checks++;
        if ({bus.lo, bus.hi} !== exp_v) begin
          errors++; $display("FAIL b2b_result[%0d] got %h/%h want %h/%h", k, bus.lo, bus.hi,
                             exp_v[63:32], exp_v[31:0]);
        end
        last_lo = exp_v[63:32];
        last_hi = exp_v[31:0];
      end
      step();  // next start lands in the cycle right after DONE
    end
  endtask

  task automatic test_annul();
    bit spurious;
    drive(1'b0, 32'd9, 32'd3, 32'd0, 32'd0, 1'b0);
    step();
    bus.start = 1'b0;
    repeat (9) step();  // cycle N+10
    bus.annul = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++; $display("FAIL annul_stall_m got %b want 1", bus.stall);
    end
    step();             // cycle N+11
    bus.annul = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL annul_stall_m1 stall %b valid %b want 0/0", bus.stall,
                         bus.result_valid);
    end
    checks++;
    if (bus.lo !== last_lo || bus.hi !== last_hi) begin
      errors++; $display("FAIL annul_hold got %h/%h want %h/%h", bus.lo, bus.hi, last_lo, last_hi);
    end
    drive(1'b0, 32'd10, 32'd4, 32'd2, 32'd2, 1'b1);
    step();
    bus.start = 1'b0;
    spurious = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (bus.result_valid !== 1'b0) spurious = 1'b1;
      step();
    end
    checks++;
    if (spurious) begin
      errors++; $display("FAIL annul_spurious_valid got 1 want 0");
    end
    @(negedge clk);     // cycle N+44
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL annul_restart_valid got %b want 1", bus.result_valid);
    end else begin
      exp_v = sb_q.pop_front();
      checks++;
      if ({bus.lo, bus.hi} !== exp_v) begin
        errors++; $display("FAIL annul_restart_result got %h/%h want %h/%h", bus.lo, bus.hi,
                           exp_v[63:32], exp_v[31:0]);
      end
      last_lo = exp_v[63:32];
      last_hi = exp_v[31:0];
    end
    step();
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'd50, 32'd3, 32'd0, 32'd0, 1'b0);
    step();
    bus.start = 1'b0;
    repeat (4) step();  // cycle N+5
    #2;
    rst = 1'b1;
    #1;                 // still before the next clock edge
    checks++;
    if (bus.stall !== 1'b0 || bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL arst_ctrl stall %b valid %b want 0/0", bus.stall, bus.result_valid);
    end
    checks++;
    if (bus.lo !== 32'h0 || bus.hi !== 32'h0) begin
      errors++; $display("FAIL arst_lohi got %h/%h want 0/0", bus.lo, bus.hi);
    end
    @(negedge clk);
    rst = 1'b0;
    last_lo = '0;
    last_hi = '0;
    step();
    drive(1'b0, 32'd1, 32'd1, 32'd1, 32'd0, 1'b1);
    step();
    bus.start = 1'b0;
    repeat (W - 1) step();
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL arst_early_valid got %b want 0", bus.result_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL arst_valid got %b want 1", bus.result_valid);
    end else begin
      exp_v = sb_q.pop_front();
      checks++;
      if ({bus.lo, bus.hi} !== exp_v) begin
        errors++; $display("FAIL arst_result got %h/%h want %h/%h", bus.lo, bus.hi,
                           exp_v[63:32], exp_v[31:0]);
      end
      last_lo = exp_v[63:32];
      last_hi = exp_v[31:0];
    end
    step();
  endtask

  task automatic test_start_ignored();
    // -100 / 7 = -14 rem -2
    drive(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1);
    step();
    bus.start = 1'b0;
    repeat (4) step();  // cycle N+5
    drive(1'b0, 32'd3, 32'd1, 32'd0, 32'd0, 1'b0);
    step();
    bus.start = 1'b0;
    repeat (W - 5) step();
    @(negedge clk);     // cycle N+33
    checks++;
    if (bus.result_valid !== 1'b1) begin
      errors++; $display("FAIL ignore_valid got %b want 1", bus.result_valid);
    end else begin
      exp_v = sb_q.pop_front();
      checks++;
      if ({bus.lo, bus.hi} !== exp_v) begin
        errors++; $display("FAIL ignore_result got %h/%h want %h/%h", bus.lo, bus.hi,
                           exp_v[63:32], exp_v[31:0]);
      end
      last_lo = exp_v[63:32];
      last_hi = exp_v[31:0];
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL ignore_no_second valid %b stall %b want 0/0", bus.result_valid,
                         bus.stall);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    logic [63:0] m;
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (k == 0) rb = 32'h0;
      m = model(rs, ra, rb);
      drive(rs, ra, rb, m[63:32], m[31:0], 1'b1);
      step();
      bus.start = 1'b0;
      repeat (W) step();
      @(negedge clk);
      checks++;
      if (bus.result_valid !== 1'b1) begin
        errors++; $display("FAIL rand_valid[%0d] got %b want 1", k, bus.result_valid);
      end else begin
        exp_v = sb_q.pop_front();
        checks++;
        if ({bus.lo, bus.hi} !== exp_v) begin
          errors++; $display("FAIL rand_result[%0d] sd %0d %h/%h got %h/%h want %h/%h", k, rs,
                             ra, rb, bus.lo, bus.hi, exp_v[63:32], exp_v[31:0]);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_divu_timing();
    test_back_to_back();
    test_annul();
    test_async_reset();
    test_start_ignored();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
